io_bus_arbiter: RTL

- Shares the memory-mapped I/O bus between two masters: the CPU memory stage and a secondary master (debug/DMA port).
- Decodes word addresses into two device windows, DEV0 and DEV1, and steers write enables and read data.
- Sits between the memory stage and the device bridge.
- The CPU has priority. A starvation counter forces a one-cycle memory-stage stall so the secondary master always makes progress.

---
 rtl/io_bus_arbiter_pkg.sv | 17 +
 rtl/io_addr_decode.sv | 24 ++
 rtl/io_bus_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/io_bus_arbiter_pkg.sv
// io_bus_arbiter_pkg
//   Shared constants and types for the I/O bus arbiter.
//   - Default byte base addresses of the two device windows.
//   - Window size in bytes (three 32-bit registers per device).
//   - Response FSM state encoding.
package io_bus_arbiter_pkg;

  localparam logic [31:0] DEV0_BASE_DEF = 32'h0000_7F00;
  localparam logic [31:0] DEV1_BASE_DEF = 32'h0000_7F10;
  localparam logic [31:0] WIN_BYTES     = 32'd12;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

endpackage

// File: rtl/io_addr_decode.sv
// io_addr_decode
//   Combinational window decode of a 30-bit word address.
//   Ports:
//     addr  in  30  word address (byte address [31:2])
//     sel0  out 1   address falls in device 0 window
//     sel1  out 1   address falls in device 1 window
module io_addr_decode
  import io_bus_arbiter_pkg::*;
#(
  parameter logic [31:0] DEV0_BASE = DEV0_BASE_DEF,
  parameter logic [31:0] DEV1_BASE = DEV1_BASE_DEF
) (
  input  logic [29:0] addr,
  output logic        sel0,
  output logic        sel1
);

  logic [31:0] byte_addr;

  assign byte_addr = {addr, 2'b00};
  assign sel0 = (byte_addr >= DEV0_BASE) && (byte_addr < DEV0_BASE + WIN_BYTES);
  assign sel1 = (byte_addr >= DEV1_BASE) && (byte_addr < DEV1_BASE + WIN_BYTES);

endmodule

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter
//   Shares the memory-mapped I/O bus between the CPU memory stage and a
//   secondary (debug/DMA) master. The CPU has priority; a starvation counter
//   forces a one-cycle memory-stage stall so the secondary master progresses.
//   Ports:
//     Clk, Reset                      clock, synchronous active-high reset
//     cpu_Req/Addr/WE/WD, cpu_RD      CPU access, same-cycle read data
//     Stall_M                         freeze memory stage this cycle
//     m2_Req/Addr/WE/WD               secondary request, held until granted
//     m2_Gnt                          one-cycle grant, access executes now
//     m2_RD, m2_Valid                 registered read data, valid next cycle
//     dev_Addr, dev_WD                word offset and write data to devices
//     dev0_WE, dev1_WE                per-device write strobes
//     dev0_RD, dev1_RD                combinational device read data
module io_bus_arbiter
  import io_bus_arbiter_pkg::*;
#(
  parameter logic [31:0] DEV0_BASE = DEV0_BASE_DEF,
  parameter logic [31:0] DEV1_BASE = DEV1_BASE_DEF,
  parameter int unsigned MAX_WAIT  = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cpu_Req,
  input  logic [29:0] cpu_Addr,
  input  logic        cpu_WE,
  input  logic [31:0] cpu_WD,
  output logic [31:0] cpu_RD,
  output logic        Stall_M,
  input  logic        m2_Req,
  input  logic [29:0] m2_Addr,
  input  logic        m2_WE,
  input  logic [31:0] m2_WD,
  output logic        m2_Gnt,
  output logic [31:0] m2_RD,
  output logic        m2_Valid,
  output logic [1:0]  dev_Addr,
  output logic [31:0] dev_WD,
  output logic        dev0_WE,
  output logic        dev1_WE,
  input  logic [31:0] dev0_RD,
  input  logic [31:0] dev1_RD
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t      state_reg, state_next;
  logic [7:0]  wait_cnt_reg, wait_cnt_next;
  logic [31:0] m2_rd_reg;

  logic        cpu_own, m2_own, any_own;
  logic [29:0] own_addr;
  logic        own_we;
  logic [31:0] own_wd;
  logic        sel0, sel1;
  logic [31:0] rd_mux;
  logic        m2_read_gnt;

  // Ownership. Everything is gated by Reset so nothing is granted or
  // strobed in a reset cycle.
  always_comb begin
    Stall_M  = !Reset && m2_Req && (wait_cnt_reg == MAX_WAIT_C);
    cpu_own  = !Reset && cpu_Req && !Stall_M;
    m2_own   = !Reset && m2_Req && !cpu_own;
    any_own  = cpu_own || m2_own;
    own_addr = '0;
    own_we   = 1'b0;
    own_wd   = '0;
    if (cpu_own) begin
      own_addr = cpu_Addr;
      own_we   = cpu_WE;
      own_wd   = cpu_WD;
    end else if (m2_own) begin
      own_addr = m2_Addr;
      own_we   = m2_WE;
      own_wd   = m2_WD;
    end
  end

  io_addr_decode #(
    .DEV0_BASE (DEV0_BASE),
    .DEV1_BASE (DEV1_BASE)
  ) u_decode (
    .addr (own_addr),
    .sel0 (sel0),
    .sel1 (sel1)
  );

  always_comb begin
    rd_mux = 32'h0;
    if (any_own && sel0) begin
      rd_mux = dev0_RD;
    end else if (any_own && sel1) begin
      rd_mux = dev1_RD;
    end
  end

  // Word offset within a window is byte address bits [3:2], i.e. word
  // address bits [1:0].
  assign dev_Addr    = own_addr[1:0];
  assign dev_WD      = own_wd;
  assign dev0_WE     = any_own && own_we && sel0;
  assign dev1_WE     = any_own && own_we && sel1;
  assign cpu_RD      = cpu_own ? rd_mux : 32'h0;
  assign m2_Gnt      = m2_own;
  assign m2_read_gnt = m2_own && !m2_WE;
  assign m2_RD       = m2_rd_reg;
  assign m2_Valid    = (state_reg == S_RESP);

  always_comb begin
    state_next = m2_read_gnt ? S_RESP : S_IDLE;
  end

  // Counter saturates at MAX_WAIT; the grant it forces clears it, so the
  // stall lasts one cycle per starvation episode.
  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (!m2_Req || m2_own) begin
      wait_cnt_next = 8'd0;
    end else if (wait_cnt_reg < MAX_WAIT_C) begin
      wait_cnt_next = wait_cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= 8'd0;
      m2_rd_reg    <= 32'h0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (m2_read_gnt) begin
        m2_rd_reg <= rd_mux;
      end
    end
  end

endmodule
